// File: rtl/add16_pkg.sv
// Shared definitions for the sequential 16-bit adder wrapper:
// FSM encoding, datapath width and settle-counter width.
package add16_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t SETTLE = 2'd1;
  localparam state_t HOLD   = 2'd2;

endpackage

// File: rtl/add16_seq_ctrl_rca.sv
// 16-bit ripple-carry adder: a plain chain of full adders with no registers,
// so its outputs are only meaningful once the carry has rippled through.
module RCA_16bits
  import add16_pkg::*;
(
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             C0,
  output logic [WIDTH-1:0] Sum,
  output logic             C4
);

  logic [WIDTH:0] carry;

  assign carry[0] = C0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign Sum[i]     = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign C4 = carry[WIDTH];

endmodule

// File: rtl/add16_seq_ctrl.sv
// Handshaked front/back end for RCA_16bits: registers operands, waits a fixed
// number of cycles for the ripple to settle, then presents the captured result.
module add16_seq_ctrl
  import add16_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic [WIDTH-1:0] acc_q
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             op_cin;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] rca_sum;
  logic             rca_cout;

  // Adder sees only the registered operands, so it is stable through SETTLE.
  RCA_16bits u_rca (
    .A   (op_a),
    .B   (op_b),
    .C0  (op_cin),
    .Sum (rca_sum),
    .C4  (rca_cout)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);
  assign acc_q     = acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      op_a     <= '0;
      op_b     <= '0;
      op_cin   <= 1'b0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      acc      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc_clr) begin
            acc <= '0;
          end
          if (in_valid) begin
            op_a   <= in_a;
            op_cin <= in_cin;
            cnt    <= CNT_W'(SETTLE_CYCLES);
            state  <= SETTLE;
            // A simultaneous clear wins, so the accumulator operand reads as zero.
            if (in_acc) begin
              op_b <= acc_clr ? '0 : acc;
            end else begin
              op_b <= in_b;
            end
          end
        end
        SETTLE: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            out_sum  <= rca_sum;
            out_cout <= rca_cout;
            acc      <= rca_sum;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_add16_seq_ctrl.sv
// Self-checking bench for add16_seq_ctrl: directed cases plus random operations
// compared against a plain-arithmetic model of the sum and accumulator.
module tb_add16_seq_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        in_cin = 1'b0;
  logic        in_acc = 1'b0;
  logic        acc_clr = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_cout;
  logic [15:0] acc_q;

  int          err_count = 0;
  int          check_count = 0;
  logic [15:0] model_acc = '0;

  add16_seq_ctrl #(.SETTLE_CYCLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_acc    (in_acc),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .acc_q     (acc_q)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: present operand, measure latency, check result,
  // optionally stall the consumer, then drain back to IDLE.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                               input logic use_acc, input logic clr, input int stall);
    logic [15:0] b_eff;
    logic [16:0] full;
    int          waited;
    int          lat;

    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
      return;
    end

    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_acc   = use_acc;
    acc_clr  = clr;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    acc_clr  = 1'b0;
    in_a     = $urandom;
    in_b     = $urandom;
    in_acc   = $urandom_range(0, 1);

    if (clr) model_acc = '0;
    b_eff     = use_acc ? model_acc : b;
    full      = {1'b0, a} + {1'b0, b_eff} + {16'b0, cin};
    model_acc = full[15:0];

    lat = 0;
    for (int i = 1; i <= N + 6; i++) begin
      if (i == 2) begin
        in_valid = 1'b1;
        acc_clr  = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      acc_clr  = 1'b0;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    checkOutput("latency", 32'(lat), 32'(N));
    checkOutput("sum", 32'(out_sum), 32'(full[15:0]));
    checkOutput("cout", 32'(out_cout), 32'(full[16]));
    checkOutput("acc_q", 32'(acc_q), 32'(model_acc));
    checkOutput("in_ready_hold", 32'(in_ready), 32'd0);

    for (int s = 0; s < stall; s++) begin
      in_valid = s[0];
      acc_clr  = 1'b1;
      tick();
      checkOutput("bp_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_sum", 32'(out_sum), 32'(full[15:0]));
      checkOutput("bp_cout", 32'(out_cout), 32'(full[16]));
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
      checkOutput("bp_acc", 32'(acc_q), 32'(model_acc));
    end
    in_valid  = 1'b0;
    acc_clr   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("drain_valid", 32'(out_valid), 32'd0);
    checkOutput("drain_ready", 32'(in_ready), 32'd1);
    checkOutput("drain_sum", 32'(out_sum), 32'(full[15:0]));
  endtask

  task automatic clearAcc();
    acc_clr = 1'b1;
    tick();
    acc_clr = 1'b0;
    model_acc = '0;
    checkOutput("clr_acc", 32'(acc_q), 32'd0);
  endtask

  task automatic resetMidSettle();
    in_a     = 16'h1111;
    in_b     = 16'h2222;
    in_acc   = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    model_acc = '0;
    checkOutput("rst_mid_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_mid_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_mid_acc", 32'(acc_q), 32'd0);
    checkOutput("rst_mid_sum", 32'(out_sum), 32'd0);
    checkOutput("rst_mid_cout", 32'(out_cout), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N + 4; i++) begin
      tick();
      checkOutput("rst_no_result", 32'(out_valid), 32'd0);
    end
    checkOutput("rst_post_acc", 32'(acc_q), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_sum", 32'(out_sum), 32'd0);
    checkOutput("reset_cout", 32'(out_cout), 32'd0);
    checkOutput("reset_acc", 32'(acc_q), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    applyStimulus(16'hA51B, 16'h52BB, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0);
    applyStimulus(16'h5555, 16'hAAAA, 1'b1, 1'b0, 1'b0, 0);

    clearAcc();
    applyStimulus(16'h0001, 16'hBEEF, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(16'h0001, 16'hBEEF, 1'b0, 1'b1, 1'b0, 10);
    applyStimulus(16'h0001, 16'hBEEF, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(16'hFFFE, 16'h0000, 1'b0, 1'b1, 1'b0, 0);
    applyStimulus(16'h1234, 16'h0F0F, 1'b0, 1'b1, 1'b1, 0);

    resetMidSettle();

    for (int t = 0; t < 20; t++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0),
                    int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/add16_seq_ctrl.md
# add16_seq_ctrl

Sequential front/back end for the 16-bit ripple-carry adder (RCA_16bits). It accepts operands over a valid/ready handshake and registers them onto the adder inputs. It waits a programmable number of clock cycles for the ripple chain to settle, then captures Sum/Cout into output registers presented over a second valid/ready handshake. An internal accumulator can replace operand B, so repeated additions need no external feedback.

## Interface
- SETTLE_CYCLES, 4: clock edges between operand acceptance and result capture; legal range 1..255; 0 is illegal.
- clk  input  1  single clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept an operand.
- in_a  input  16  operand A.
- in_b  input  16  operand B; ignored when in_acc=1.
- in_cin  input  1  carry-in to bit 0.
- in_acc  input  1  use accumulator as operand B.
- acc_clr  input  1  synchronous accumulator clear; honoured only in IDLE.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_sum  output  16  captured Sum.
- out_cout  output  1  captured carry-out of bit 15.
- acc_q  output  16  current accumulator value.

## Operation
- FSM states: IDLE, SETTLE, HOLD. Reset state is IDLE.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid && in_ready, latch in_a into op_a, latch (in_acc ? acc : in_b) into op_b, latch in_cin into op_cin, load cnt=SETTLE_CYCLES, and go to SETTLE.
- SETTLE: in_ready=0, out_valid=0.
  - Each edge decrements cnt.
  - On the edge where cnt==1, capture out_sum/out_cout from the adder outputs, set acc <= adder Sum, and go to HOLD.
- HOLD: out_valid=1, in_ready=0.
  - On out_valid && out_ready, go to IDLE.
  - out_sum/out_cout stay frozen until the next capture.
- acc_clr in IDLE sets acc to 0 at the edge.
  - If acc_clr coincides with an accepted in_acc=1 operand, the clear applies first and op_b=0x0000.
  - acc_clr in SETTLE or HOLD is ignored.
- Accumulator update:
  - Every capture writes acc, whatever the value of in_acc.
  - The 16-bit sum wraps modulo 2^16.
  - Carry-out goes only to out_cout, never into acc.
- Adder operands come only from op_a/op_b/op_cin registers, never from ports. They are held constant from acceptance through capture.
- No overlap: a new operand is never accepted while a result is outstanding.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE, in_ready=1, out_valid=0.
  - out_sum=0x0000, out_cout=0, acc_q=0x0000.
  - op registers and cnt are 0.
  - Any in-flight operation is discarded.
- Latency: operand accepted at edge k; result captured and out_valid high after edge k+SETTLE_CYCLES.
- Earliest next acceptance:
  - Edge k+SETTLE_CYCLES+2, when out_ready is already high during the first HOLD cycle.
  - Peak throughput is one result per SETTLE_CYCLES+2 cycles.
- in_ready and out_valid are pure state decodes (registered state), with no combinational path from in_valid or out_ready.
- Backpressure: out_ready low holds HOLD indefinitely; out_valid, out_sum and out_cout stay stable.
- in_valid in SETTLE or HOLD is ignored; the source must hold its request until in_ready.
- SETTLE_CYCLES must cover the adder's worst-case full-carry ripple delay at the target clock period.

## Structure
- Shared package add16_pkg holds:
  - the state encoding (IDLE=2'd0, SETTLE=2'd1, HOLD=2'd2);
  - the data width constant (16);
  - the settle-counter width (8).
- One sub-module: RCA_16bits instantiated as u_rca.
  - C0 is driven by op_cin.
  - A and B are driven by op_a and op_b.
  - Sum and C4 are sampled only at capture.
- FSM, counter, operand/result registers and accumulator live in add16_seq_ctrl. No further hierarchy.

## Test plan
- Plain adds:
  - A=0xA51B, B=0x52BB, cin=0 -> out_sum=0xF7D6, out_cout=0; out_valid rises exactly SETTLE_CYCLES edges after acceptance.
  - A=0xFFFF, B=0xFFFF, cin=0 -> 0xFFFE, cout=1.
  - A=0x5555, B=0xAAAA, cin=1 -> 0x0000, cout=1; full ripple, checked with SETTLE_CYCLES matched to the gate-level worst case.
- Accumulate:
  - acc_clr, then three ops A=0x0001, in_acc=1 -> out_sum 0x0001, 0x0002, 0x0003; acc_q tracks.
  - Then A=0xFFFE, in_acc=1 -> out_sum 0x0001, cout=1, acc_q=0x0001 (wrap).
- Backpressure: hold out_ready=0 for 10 cycles in HOLD -> out_valid stays 1, data unchanged, in_ready=0, in_valid pulses ignored. After out_ready=1, IDLE on the next edge.
- Coincidence: acc_clr=1 together with an accepted in_acc=1, A=0x1234 -> result 0x1234, not acc+0x1234.
- Reset mid-SETTLE: assert rst_n=0 two cycles after acceptance -> immediately out_valid=0, in_ready=1, acc_q=0x0000, out_sum=0x0000. No result is produced after release.
